// File: rtl/fpu_pkg.sv
// Shared FPU constants: mantissa/product widths, multiplier FSM encodings, step count.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

   localparam int MANT_W    = 24;
   localparam int PROD_W    = 2 * MANT_W;
   localparam int MUL_STEPS = 24;
   localparam int CNT_W     = $clog2(MUL_STEPS);

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

   // Either operand zero makes the product zero, so the iteration can be skipped.
   function automatic logic is_zero_op(input logic [MANT_W-1:0] x,
                                       input logic [MANT_W-1:0] y);
      return (x == '0) || (y == '0);
   endfunction

endpackage

// File: rtl/add_48_bit.sv
// 48-bit unsigned ripple-carry adder feeding the multiplier accumulator.
// Latency: combinational, zero cycles; the carry chain is the critical path.
// Backpressure: none; carry-out is dropped because the product cannot exceed 48 bits.
module add_48_bit
   import fpu_pkg::*;
(
   input  logic [PROD_W-1:0] acc_dat,
   input  logic [PROD_W-1:0] addend_dat,
   output logic [PROD_W-1:0] sum_dat
);

   // Bit-serial carry propagation from LSB to MSB.
   always_comb begin : ripple
      logic c;
      c       = 1'b0;
      sum_dat = '0;
      for (int i = 0; i < PROD_W; i++) begin
         sum_dat[i] = acc_dat[i] ^ addend_dat[i] ^ c;
         c          = (acc_dat[i] & addend_dat[i]) | (c & (acc_dat[i] ^ addend_dat[i]));
      end
   end

endmodule

// File: rtl/mant_mul_seq.sv
// Iterative radix-2 shift-and-add 24x24 mantissa multiplier with start/done handshake.
// Latency: 25 cycles start to done (1 cycle when either operand is zero); one step per clock.
// Backpressure: start is ignored while busy; kill aborts to IDLE without a done pulse.
module mant_mul_seq
   import fpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              kill,
   input  logic [MANT_W-1:0] a,
   input  logic [MANT_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_STEPS - 1);

   mul_state_e        state_q, state_d;
   logic [PROD_W-1:0] mcand_q, mcand_d;
   logic [MANT_W-1:0] mplr_q, mplr_d;
   logic [PROD_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PROD_W-1:0] product_q, product_d;

   logic [PROD_W-1:0] add_sum;
   logic [PROD_W-1:0] acc_step;
   logic              accept;
   logic              last_step;

   add_48_bit u_add (
      .acc_dat    (acc_q),
      .addend_dat (mcand_q),
      .sum_dat    (add_sum)
   );

   assign acc_step  = mplr_q[0] ? add_sum : acc_q;
   assign accept    = (state_q == MUL_IDLE) && start && !kill;
   assign last_step = (cnt_q == LAST_CNT);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MUL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; kill overrides every transition.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         MUL_IDLE: begin
            if (start) begin
               state_d = is_zero_op(a, b) ? MUL_DONE : MUL_RUN;
            end
         end
         MUL_RUN: begin
            if (last_step) begin
               state_d = MUL_DONE;
            end
         end
         MUL_DONE: state_d = MUL_IDLE;
         default:  state_d = MUL_IDLE;
      endcase
      if (kill) begin
         state_d = MUL_IDLE;
      end
   end

   // FSM outputs are pure decodes of the state register.
   always_comb begin
      busy    = (state_q != MUL_IDLE);
      done    = (state_q == MUL_DONE);
      product = product_q;
   end

   // Datapath next values: operand capture, shift/accumulate step, result load on DONE entry.
   always_comb begin
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      if (accept) begin
         mcand_d = {{(PROD_W-MANT_W){1'b0}}, a};
         mplr_d  = b;
         acc_d   = '0;
         cnt_d   = '0;
         if (is_zero_op(a, b)) begin
            product_d = '0;
         end
      end else if ((state_q == MUL_RUN) && !kill) begin
         acc_d   = acc_step;
         mcand_d = {mcand_q[PROD_W-2:0], 1'b0};
         mplr_d  = {1'b0, mplr_q[MANT_W-1:1]};
         cnt_d   = cnt_q + 1'b1;
         if (last_step) begin
            // The final partial sum goes straight to the output so it is visible with done.
            product_d = acc_step;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q   <= '0;
         mplr_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

endmodule

// File: tb/tb_mant_mul_seq.sv
// Self-checking bench for mant_mul_seq: directed table, random ops against a product model,
// and hand-written kill, start-while-busy and asynchronous-reset sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_mant_mul_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        kill;
   logic [23:0] a;
   logic [23:0] b;
   logic        busy;
   logic        done;
   logic [47:0] product;

   int n_chk;
   int n_err;
   logic [47:0] last_prod;

   mant_mul_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .kill    (kill),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] va;
      logic [23:0] vb;
      logic [47:0] exp_prod;
      int          exp_lat;
   } vec_t;

   // Reference: the product is plain unsigned multiplication; timing is one cycle for a
   // zero operand, otherwise one cycle per mantissa bit plus the DONE cycle.
   function automatic logic [47:0] ref_mul(input logic [23:0] x, input logic [23:0] y);
      logic [63:0] p;
      p = 64'(x) * 64'(y);
      return p[47:0];
   endfunction

   function automatic int ref_lat(input logic [23:0] x, input logic [23:0] y);
      return ((x == 24'd0) || (y == 24'd0)) ? 1 : 25;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one multiply and follow it to completion, checking latency, product, busy span,
   // single-cycle done and result hold after return to IDLE.
   task automatic do_op(input string name, input logic [23:0] oa, input logic [23:0] ob,
                        input logic [47:0] exp_prod, input int exp_lat);
      int n;
      int bc;
      a = oa; b = ob; start = 1'b1;
      tick();
      start = 1'b0;
      n  = 1;
      bc = int'(busy);
      while (!done && n < 100) begin
         tick();
         n++;
         bc += int'(busy);
      end
      chk({name, " latency"}, 64'(n), 64'(exp_lat));
      chk({name, " product"}, 64'(product), 64'(exp_prod));
      chk({name, " busy cycles"}, 64'(bc), 64'(exp_lat));
      tick();
      chk({name, " done one cycle"}, 64'(done), 64'd0);
      chk({name, " idle after"}, 64'(busy), 64'd0);
      chk({name, " product held"}, 64'(product), 64'(exp_prod));
      last_prod = exp_prod;
   endtask

   initial begin
      vec_t vecs[6];
      int n;
      logic saw_done;
      logic [23:0] ra;
      logic [23:0] rb;

      n_chk = 0;
      n_err = 0;
      last_prod = '0;

      vecs[0] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 25};
      vecs[1] = '{24'hC00000, 24'hC00000, 48'h900000000000, 25};
      vecs[2] = '{24'h800000, 24'h800000, 48'h400000000000, 25};
      vecs[3] = '{24'h000000, 24'hABCDEF, 48'h000000000000, 1};
      vecs[4] = '{24'h123456, 24'h000000, 48'h000000000000, 1};
      vecs[5] = '{24'h000001, 24'h000001, 48'h000000000001, 25};

      rst_n = 1'b0; start = 1'b0; kill = 1'b0; a = '0; b = '0;
      #12;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset product", 64'(product), 64'd0);
      #10 rst_n = 1'b1;
      tick();

      // Directed table; entries 1 and 2 run back to back with start the cycle after done falls.
      for (int i = 0; i < 6; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].exp_prod, vecs[i].exp_lat);
      end

      // kill together with start in IDLE: nothing is captured.
      a = 24'h000003; b = 24'h000005; start = 1'b1; kill = 1'b1;
      tick();
      start = 1'b0; kill = 1'b0;
      chk("kill+start idle busy", 64'(busy), 64'd0);
      chk("kill+start idle product", 64'(product), 64'(last_prod));

      // Kill at cycle 10 of a running multiply.
      a = 24'h123456; b = 24'h654321; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk("kill pre busy", 64'(busy), 64'd1);
      kill = 1'b1;
      tick();
      kill = 1'b0;
      chk("kill busy", 64'(busy), 64'd0);
      chk("kill done", 64'(done), 64'd0);
      chk("kill product", 64'(product), 64'(last_prod));
      saw_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         saw_done = saw_done | done;
      end
      chk("kill no done", 64'(saw_done), 64'd0);
      do_op("after kill", 24'h000001, 24'h000001, 48'h000000000001, 25);

      // Start pulses mid-run with changed operands, and a start while in DONE, are ignored.
      a = 24'h123456; b = 24'h654321; start = 1'b1;
      tick();
      start = 1'b0;
      a = 24'h00000F; b = 24'h0000F0;
      n = 1;
      while (!done && n < 100) begin
         start = (n == 4 || n == 23);
         tick();
         n++;
      end
      start = 1'b0;
      chk("restart latency", 64'(n), 64'd25);
      chk("restart product", 64'(product), 64'(ref_mul(24'h123456, 24'h654321)));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start in done ignored", 64'(busy), 64'd0);
      chk("start in done product", 64'(product), 64'(ref_mul(24'h123456, 24'h654321)));
      last_prod = ref_mul(24'h123456, 24'h654321);

      // Randomized operands, some forced to zero, against the reference model.
      for (int i = 0; i < 16; i++) begin
         ra = 24'($urandom());
         rb = 24'($urandom());
         if ($urandom_range(0, 4) == 0) ra = '0;
         if ($urandom_range(0, 4) == 0) rb = '0;
         do_op($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb), ref_lat(ra, rb));
      end

      // Asynchronous reset mid-RUN, away from any clock edge.
      a = 24'hABCDEF; b = 24'hFEDCBA; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("async rst busy", 64'(busy), 64'd0);
      chk("async rst done", 64'(done), 64'd0);
      chk("async rst product", 64'(product), 64'd0);
      #3 rst_n = 1'b1;
      tick();
      do_op("after rst", 24'hABCDEF, 24'hFEDCBA, ref_mul(24'hABCDEF, 24'hFEDCBA), 25);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
